// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sub-word formatting helpers for dmem_arbiter.
// Misalignment checking is used only when DMEM_ARBITER_MISALIGN_ERR_EN is defined.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'b0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            F3_W:    return word;
            default: return word;
        endcase
    endfunction

    // Unsigned codes are loads only; for stores they are reserved and act as words.
    function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_B || (!we && f3 == F3_BU)) return 1'b0;
        if (f3 == F3_H || (!we && f3 == F3_HU)) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational store lane/byte-enable formatting and load extraction.
// With DMEM_ARBITER_MISALIGN_ERR_EN, misaligned accesses are suppressed and flagged.
module dmem_lane_fmt
    import dmem_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] lanes,
    output logic [31:0] rdata,
    output logic        err
);

`ifdef DMEM_ARBITER_MISALIGN_ERR_EN
    assign err = misaligned(we, funct3, off);
`else
    assign err = 1'b0;
`endif

    assign be    = (we && !err) ? store_be(funct3, off) : 4'b0000;
    assign lanes = store_lanes(funct3, wdata);
    assign rdata = (we || err) ? 32'h0 : load_extract(funct3, off, mem_rdata);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a word-wide data memory with sub-word formatting.
// Define DMEM_ARBITER_MISALIGN_ERR_EN to report and suppress misaligned accesses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DM_ADDRESS-1:0] m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [2:0]            m0_funct3,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DM_ADDRESS-1:0] m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [2:0]            m1_funct3,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_err,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t                state;
    logic                  last_grant;
    logic                  win;
    logic [1:0]            gnt_q;
    logic [1:0]            rvalid_q;
    logic                  lat_we;
    logic [DM_ADDRESS-1:0] lat_addr;
    logic [DATA_W-1:0]     lat_wdata;
    logic [2:0]            lat_f3;

    logic                  any_req;
    logic                  pick;
    logic                  in_access;
    logic [3:0]            fmt_be;
    logic [DATA_W-1:0]     fmt_lanes;
    logic [DATA_W-1:0]     fmt_rdata;
    logic                  fmt_err;

    assign any_req = m0_req | m1_req;
    // On a tie the requester that did not win last time goes next.
    assign pick    = (m0_req && m1_req) ? ~last_grant : m1_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win        <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_f3     <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state)
                IDLE, RESP: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        win        <= pick;
                        last_grant <= pick;
                        gnt_q      <= pick ? 2'b10 : 2'b01;
                        lat_we     <= pick ? m1_we     : m0_we;
                        lat_addr   <= pick ? m1_addr   : m0_addr;
                        lat_wdata  <= pick ? m1_wdata  : m0_wdata;
                        lat_f3     <= pick ? m1_funct3 : m0_funct3;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state    <= RESP;
                    rvalid_q <= win ? 2'b10 : 2'b01;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dmem_lane_fmt u_fmt (
        .we        (lat_we),
        .funct3    (lat_f3),
        .off       (lat_addr[1:0]),
        .wdata     (lat_wdata),
        .mem_rdata (mem_rdata),
        .be        (fmt_be),
        .lanes     (fmt_lanes),
        .rdata     (fmt_rdata),
        .err       (fmt_err)
    );

    // Reset in the ACCESS cycle must squash the strobes before the state register clears.
    assign in_access = (state == ACCESS) && !reset;

    assign mem_addr  = in_access ? {lat_addr[DM_ADDRESS-1:2], 2'b00} : '0;
    assign mem_re    = in_access && !lat_we;
    assign mem_be    = in_access ? fmt_be : 4'b0000;
    assign mem_wdata = (in_access && lat_we) ? fmt_lanes : '0;

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rvalid_q[0] ? fmt_rdata : '0;
    assign m1_rdata  = rvalid_q[1] ? fmt_rdata : '0;
    assign m0_err    = rvalid_q[0] & fmt_err;
    assign m1_err    = rvalid_q[1] & fmt_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; honours DMEM_ARBITER_MISALIGN_ERR_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [2:0]  m0_funct3, m1_funct3;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [8:0]  mem_addr;
    logic        mem_re;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [8:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_funct3 = f3; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_funct3 = f3; m0_wdata = wd;
        end
    endtask

    // One isolated access from IDLE: ACCESS checks, RESP checks, then back to IDLE.
    task automatic access(input string tag, input bit m, input bit we, input logic [8:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [8:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input bit exp_err);
        drive(m, 1'b1, we, addr, f3, wd);
        tick;
        chk({tag, ".gnt"},   m ? m1_gnt : m0_gnt, 1);
        chk({tag, ".ognt"},  m ? m0_gnt : m1_gnt, 0);
        chk({tag, ".addr"},  mem_addr, exp_addr);
        chk({tag, ".re"},    mem_re, !we);
        chk({tag, ".be"},    mem_be, exp_be);
        chk({tag, ".wdata"}, mem_wdata, exp_wdata);
        // Scramble the request fields: the latched copy must be used from here on.
        drive(m, 1'b0, !we, 9'h1FF, 3'b111, 32'hFFFF_FFFF);
        tick;
        chk({tag, ".rvalid"},  m ? m1_rvalid : m0_rvalid, 1);
        chk({tag, ".orvalid"}, m ? m0_rvalid : m1_rvalid, 0);
        chk({tag, ".rdata"},   m ? m1_rdata : m0_rdata, exp_rdata);
        chk({tag, ".err"},     m ? m1_err : m0_err, exp_err);
        chk({tag, ".gnt2"},    m ? m1_gnt : m0_gnt, 0);
        tick;
        chk({tag, ".idle"},    m ? m1_rvalid : m0_rvalid, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        mem_rdata = '0;
        tick;
        tick;
        chk("rst.m0_gnt", m0_gnt, 0);
        chk("rst.m1_rvalid", m1_rvalid, 0);
        chk("rst.mem_re", mem_re, 0);
        chk("rst.mem_be", mem_be, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.m0_rdata", m0_rdata, 0);
        reset = 1'b0;

        mem_rdata = 32'hDEAD_BEEF;
        access("lw", 0, 0, 9'h004, 3'b010, 32'h0, 9'h004, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0);
        access("sb", 1, 1, 9'h00A, 3'b000, 32'h0000_00A5, 9'h008, 4'b0100, 32'hA5A5_A5A5, 32'h0, 0);

        mem_rdata = 32'h80FF_7F01;
        access("lb",  0, 0, 9'h013, 3'b000, 32'h0, 9'h010, 4'b0000, 32'h0, 32'hFFFF_FF80, 0);
        access("lbu", 0, 0, 9'h013, 3'b100, 32'h0, 9'h010, 4'b0000, 32'h0, 32'h0000_0080, 0);
        access("lh",  1, 0, 9'h012, 3'b001, 32'h0, 9'h010, 4'b0000, 32'h0, 32'hFFFF_80FF, 0);
        access("lhu", 1, 0, 9'h010, 3'b101, 32'h0, 9'h010, 4'b0000, 32'h0, 32'h0000_7F01, 0);
        access("sh",  1, 1, 9'h00E, 3'b001, 32'h1234_BEEF, 9'h00C, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0);

        // Both requesting continuously; m1 was served last so m0 wins first.
        drive(0, 1, 0, 9'h020, 3'b010, 32'h0);
        drive(1, 1, 0, 9'h024, 3'b010, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("rr%0d.m0_gnt", k), m0_gnt, (k % 4) == 1);
            chk($sformatf("rr%0d.m1_gnt", k), m1_gnt, (k % 4) == 3);
            chk($sformatf("rr%0d.m0_rv", k), m0_rvalid, (k % 4) == 2);
            chk($sformatf("rr%0d.m1_rv", k), m1_rvalid, (k % 4) == 0);
            chk($sformatf("rr%0d.both", k), m0_gnt & m1_gnt, 0);
            if (k == 12) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        tick;
        chk("rr.idle_gnt", {m0_gnt, m1_gnt}, 0);
        chk("rr.idle_rv", {m0_rvalid, m1_rvalid}, 0);

        // Reset during the ACCESS cycle of a store.
        drive(0, 1, 1, 9'h00C, 3'b010, 32'h1234_5678);
        tick;
        chk("rstmid.gnt", m0_gnt, 1);
        chk("rstmid.be_pre", mem_be, 4'b1111);
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("rstmid.be", mem_be, 0);
        tick;
        chk("rstmid.rvalid", m0_rvalid, 0);
        chk("rstmid.be2", mem_be, 0);
        reset = 1'b0;
        tick;
        chk("rstmid.idle_gnt", m0_gnt, 0);
        chk("rstmid.idle_rv", m0_rvalid, 0);
        chk("rstmid.idle_re", mem_re, 0);

`ifdef DMEM_ARBITER_MISALIGN_ERR_EN
        access("sw_mis", 0, 1, 9'h006, 3'b010, 32'hCAFE_F00D, 9'h004, 4'b0000, 32'hCAFE_F00D, 32'h0, 1);
        access("lh_mis", 1, 0, 9'h011, 3'b001, 32'h0, 9'h010, 4'b0000, 32'h0, 32'h0, 1);
`else
        access("sw_mis", 0, 1, 9'h006, 3'b010, 32'hCAFE_F00D, 9'h004, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);
        access("lh_mis", 1, 0, 9'h011, 3'b001, 32'h0, 9'h010, 4'b0000, 32'h0, 32'h0000_7F01, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
